// File: rtl/mii_tx_scheduler.sv
// Two-requester round-robin MII transmit scheduler: frames payload from
// show-ahead sources as START, data, TERM/IDLE fill and inter-packet gap.
module mii_tx_scheduler #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         CTRL_WIDTH    = 8,
    parameter logic [7:0] IDLE_CODE     = 8'h07,
    parameter logic [7:0] START_CODE    = 8'hFB,
    parameter logic [7:0] TERM_CODE     = 8'hFD,
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter int         MIN_LEN       = 46,
    parameter int         MAX_LEN       = 150,
    parameter int         IPG_BYTES     = 12,
    parameter int         LEN_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req,
    input  logic [LEN_WIDTH-1:0]  i_len0,
    input  logic [LEN_WIDTH-1:0]  i_len1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic [1:0]            o_rd,
    output logic [1:0]            o_grant,
    output logic [1:0]            o_done,
    output logic [1:0]            o_reject,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_busy
);
    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_PAYLOAD, ST_TERM, ST_IPG} state_t;

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    state_t                state, state_nx;
    logic                  sel, sel_nx;
    logic                  last_sel, last_sel_nx;
    logic [LEN_WIDTH-1:0]  words_left, words_left_nx;
    logic [LEN_WIDTH-1:0]  ipg_k, ipg_k_nx;
    logic [LEN_WIDTH-1:0]  ipg_left, ipg_left_nx;
    logic [2:0]            rem, rem_nx;
    logic [DATA_WIDTH-1:0] tx_data_nx;
    logic [CTRL_WIDTH-1:0] tx_ctrl_nx;
    logic                  pick, legal, last_word;
    logic [LEN_WIDTH-1:0]  pick_len;

    // Extra IDLE words needed after the tail; the arbitration IDLE word is counted too.
    function automatic logic [LEN_WIDTH-1:0] ipg_words(input logic [2:0] r);
        int tail, need, words;
        tail  = (r == 3'd0) ? 7 : 7 - int'(r);
        need  = (IPG_BYTES > tail) ? IPG_BYTES - tail : 0;
        words = (need + 7) / 8;
        return (words > 0) ? LEN_WIDTH'(words - 1) : '0;
    endfunction

    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        last_sel_nx   = last_sel;
        words_left_nx = words_left;
        ipg_k_nx      = ipg_k;
        ipg_left_nx   = ipg_left;
        rem_nx        = rem;
        tx_data_nx    = {8{IDLE_CODE}};
        tx_ctrl_nx    = '1;
        o_rd          = '0;
        o_grant       = '0;
        o_done        = '0;
        o_reject      = '0;
        o_busy        = (state != ST_IDLE);
        pick          = (i_req == 2'b11) ? ~last_sel : i_req[1];
        pick_len      = pick ? i_len1 : i_len0;
        legal         = (pick_len >= MIN_L) && (pick_len <= MAX_L);
        last_word     = (words_left == LEN_WIDTH'(1));

        case (state)
            ST_IDLE: begin
                if (i_req != 2'b00 && !i_rst) begin
                    last_sel_nx = pick;
                    if (legal) begin
                        sel_nx        = pick;
                        words_left_nx = (pick_len >> 3) + LEN_WIDTH'(pick_len[2:0] != 3'd0);
                        rem_nx        = pick_len[2:0];
                        ipg_k_nx      = ipg_words(pick_len[2:0]);
                        state_nx      = ST_SOF;
                    end else begin
                        o_reject[pick] = 1'b1;
                    end
                end
            end
            ST_SOF: begin
                o_grant[sel] = 1'b1;
                tx_data_nx   = {{7{PREAMBLE_BYTE}}, START_CODE};
                tx_ctrl_nx   = CTRL_WIDTH'(1);
                state_nx     = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                o_grant[sel]  = 1'b1;
                o_rd[sel]     = 1'b1;
                tx_data_nx    = sel ? i_data1 : i_data0;
                tx_ctrl_nx    = '0;
                words_left_nx = words_left - LEN_WIDTH'(1);
                if (last_word) begin
                    if (rem == 3'd0) begin
                        state_nx = ST_TERM;
                    end else begin
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (3'(i) == rem) begin
                                tx_data_nx[8*i +: 8] = TERM_CODE;
                                tx_ctrl_nx[i]        = 1'b1;
                            end else if (3'(i) > rem) begin
                                tx_data_nx[8*i +: 8] = IDLE_CODE;
                                tx_ctrl_nx[i]        = 1'b1;
                            end
                        end
                        o_done[sel] = 1'b1;
                        ipg_left_nx = ipg_k;
                        state_nx    = (ipg_k != '0) ? ST_IPG : ST_IDLE;
                    end
                end
            end
            ST_TERM: begin
                o_grant[sel] = 1'b1;
                o_done[sel]  = 1'b1;
                tx_data_nx   = {{7{IDLE_CODE}}, TERM_CODE};
                ipg_left_nx  = ipg_k;
                state_nx     = (ipg_k != '0) ? ST_IPG : ST_IDLE;
            end
            ST_IPG: begin
                ipg_left_nx = ipg_left - LEN_WIDTH'(1);
                if (ipg_left == LEN_WIDTH'(1)) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // An aborted frame must not pop, complete or reject anything.
        if (i_rst) begin
            o_rd     = '0;
            o_done   = '0;
            o_reject = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            last_sel   <= 1'b1;
            words_left <= '0;
            ipg_k      <= '0;
            ipg_left   <= '0;
            rem        <= '0;
            o_tx_data  <= {8{IDLE_CODE}};
            o_tx_ctrl  <= '1;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            last_sel   <= last_sel_nx;
            words_left <= words_left_nx;
            ipg_k      <= ipg_k_nx;
            ipg_left   <= ipg_left_nx;
            rem        <= rem_nx;
            o_tx_data  <= tx_data_nx;
            o_tx_ctrl  <= tx_ctrl_nx;
        end
    end
endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Randomized bench for mii_tx_scheduler; a frame-level byte-stream model
// predicts every cycle of grant/rd/done/reject/busy and the transmit words.
module tb_mii_tx_scheduler;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam int MEMSZ = 8192;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_req;
    logic [7:0]  i_len0, i_len1;
    logic [63:0] i_data0, i_data1;
    logic [1:0]  o_rd, o_grant, o_done, o_reject;
    logic [63:0] o_tx_data;
    logic [7:0]  o_tx_ctrl;
    logic        o_busy;

    always #5 clk = ~clk;

    mii_tx_scheduler dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
        .i_data0(i_data0), .i_data1(i_data1), .o_rd(o_rd), .o_grant(o_grant),
        .o_done(o_done), .o_reject(o_reject), .o_tx_data(o_tx_data),
        .o_tx_ctrl(o_tx_ctrl), .o_busy(o_busy)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic [1:0]  g;
        logic [1:0]  rd;
        logic [1:0]  dn;
        logic        busy;
        int          pidx;
    } rec_t;

    rec_t        q[$];
    logic [63:0] mem0 [MEMSZ];
    logic [63:0] mem1 [MEMSZ];
    int          ptr [2];
    int          mptr [2];
    int          checks = 0;
    int          failures = 0;
    int          last_pick;
    logic [63:0] prev_d;
    logic [7:0]  prev_c;
    logic        nrst;
    logic [1:0]  nreq;
    logic [7:0]  nlen0, nlen1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int n);
        return (n == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [63:0] mem_word(input int n, input int idx);
        return (n == 1) ? mem1[idx % MEMSZ] : mem0[idx % MEMSZ];
    endfunction

    // Serialise the whole frame as a byte stream, then cut it into 8-byte words.
    task automatic build_frame(input int n, input int len);
        logic [7:0]  b[$];
        logic        cb[$];
        logic [63:0] w;
        int          tail, k, nchunks, nw;
        rec_t        r;
        b.push_back(8'hFB); cb.push_back(1'b1);
        repeat (7) begin b.push_back(8'h55); cb.push_back(1'b0); end
        for (int j = 0; j < len; j++) begin
            w = mem_word(n, mptr[n] + j / 8);
            b.push_back(w[8*(j%8) +: 8]);
            cb.push_back(1'b0);
        end
        b.push_back(8'hFD); cb.push_back(1'b1);
        tail = 0;
        while (b.size() % 8 != 0) begin
            b.push_back(8'h07); cb.push_back(1'b1); tail++;
        end
        k = 0;
        while (tail + 8 * k + 8 < 12) k++;
        nw      = (len + 7) / 8;
        nchunks = b.size() / 8;
        for (int i = 0; i < nchunks; i++) begin
            for (int l = 0; l < 8; l++) begin
                r.d[8*l +: 8] = b[8*i + l];
                r.c[l]        = cb[8*i + l];
            end
            r.g    = oh(n);
            r.rd   = (i >= 1 && i <= nw) ? oh(n) : 2'b00;
            r.dn   = (i == nchunks - 1) ? oh(n) : 2'b00;
            r.busy = 1'b1;
            r.pidx = (i >= 1 && i <= nw) ? i - 1 : -1;
            q.push_back(r);
        end
        for (int i = 0; i < k; i++) begin
            r.d = IDLE_W; r.c = 8'hFF; r.g = 2'b00; r.rd = 2'b00; r.dn = 2'b00;
            r.busy = 1'b1; r.pidx = -1;
            q.push_back(r);
        end
        mptr[n] = (mptr[n] + nw) % MEMSZ;
    endtask

    task automatic cycle();
        logic [1:0] pop, exp_rej;
        rec_t       r;
        int         p, len;
        @(negedge clk);
        i_rst = nrst; i_req = nreq; i_len0 = nlen0; i_len1 = nlen1;
        #1;
        chk("tx_data", o_tx_data, prev_d);
        chk("tx_ctrl", 64'(o_tx_ctrl), 64'(prev_c));
        if (i_rst) begin
            chk("rst_done", 64'(o_done), 64'd0);
            chk("rst_reject", 64'(o_reject), 64'd0);
            q.delete();
            last_pick = 1;
            prev_d = IDLE_W; prev_c = 8'hFF;
            ptr[0] = mptr[0]; ptr[1] = mptr[1];
        end else if (q.size() == 0) begin
            exp_rej = 2'b00;
            if (i_req != 2'b00) begin
                p   = (i_req == 2'b11) ? 1 - last_pick : (i_req[1] ? 1 : 0);
                len = (p == 1) ? int'(i_len1) : int'(i_len0);
                last_pick = p;
                if (len >= 46 && len <= 150) build_frame(p, len);
                else exp_rej = oh(p);
            end
            chk("idle_grant", 64'(o_grant), 64'd0);
            chk("idle_rd", 64'(o_rd), 64'd0);
            chk("idle_done", 64'(o_done), 64'd0);
            chk("idle_busy", 64'(o_busy), 64'd0);
            chk("reject", 64'(o_reject), 64'(exp_rej));
            prev_d = IDLE_W; prev_c = 8'hFF;
        end else begin
            r = q.pop_front();
            chk("grant", 64'(o_grant), 64'(r.g));
            chk("rd", 64'(o_rd), 64'(r.rd));
            chk("done", 64'(o_done), 64'(r.dn));
            chk("busy", 64'(o_busy), 64'(r.busy));
            chk("frame_reject", 64'(o_reject), 64'd0);
            prev_d = r.d; prev_c = r.c;
        end
        pop = o_rd;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) if (pop[n]) ptr[n] = (ptr[n] + 1) % MEMSZ;
        i_data0 = mem0[ptr[0]];
        i_data1 = mem1[ptr[1]];
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic logic [7:0] rand_len();
        case ($urandom_range(0, 5))
            0: return 8'd45;
            1: return 8'd46;
            2: return 8'd150;
            3: return 8'd151;
            4: return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(40, 160));
        endcase
    endfunction

    initial begin
        logic hit;
        for (int i = 0; i < MEMSZ; i++) begin
            mem0[i] = {$urandom, $urandom};
            mem1[i] = {$urandom, $urandom};
        end
        ptr[0] = 0; ptr[1] = 0; mptr[0] = 0; mptr[1] = 0;
        i_data0 = mem0[0]; i_data1 = mem1[0];
        i_rst = 1'b1; i_req = 2'b00; i_len0 = '0; i_len1 = '0;
        last_pick = 1; prev_d = IDLE_W; prev_c = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx_data", o_tx_data, IDLE_W);
        chk("reset_tx_ctrl", 64'(o_tx_ctrl), 64'hFF);
        chk("reset_grant", 64'(o_grant), 64'd0);
        chk("reset_rd", 64'(o_rd), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_reject", 64'(o_reject), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);

        nrst = 1'b0; nreq = 2'b00; nlen0 = 8'd46; nlen1 = 8'd46;
        run(3);
        nreq = 2'b01; nlen0 = 8'd64;  cycle(); nreq = 2'b00; run(16);
        nreq = 2'b10; nlen1 = 8'd46;  cycle(); nreq = 2'b00; run(14);
        nreq = 2'b11; nlen0 = 8'd46; nlen1 = 8'd46; run(40); nreq = 2'b00; run(12);
        nreq = 2'b01; nlen0 = 8'd45;  cycle(); nreq = 2'b00; run(2);
        nreq = 2'b10; nlen1 = 8'd151; cycle(); nreq = 2'b00; run(2);
        nreq = 2'b01; nlen0 = 8'd150; cycle(); nreq = 2'b00; run(25);

        nreq = 2'b01; nlen0 = 8'd64; cycle(); nreq = 2'b00;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            if (q.size() > 0 && q[0].pidx == 2) hit = 1'b1;
        end
        chk("reach_payload3", 64'(hit), 64'd1);
        nrst = 1'b1; cycle(); nrst = 1'b0;
        nreq = 2'b11; nlen0 = 8'd46; nlen1 = 8'd46; run(30); nreq = 2'b00; run(12);

        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!nreq[n]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        nreq[n] = 1'b1;
                        if (n == 0) nlen0 = rand_len();
                        else        nlen1 = rand_len();
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    nreq[n] = 1'b0;
                end
            end
            cycle();
        end
        nreq = 2'b00;
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mii_tx_scheduler.md
Name: mii_tx_scheduler

Overview:
- Two-requester transmit scheduler for the 64-bit/8-lane MII transmit path.
- Arbitrates round-robin between two frame sources and pulls their payload words through a show-ahead read strobe.
- Encodes each frame as: start word, payload words, TERM and IDLE fill, then the minimum inter-packet gap of IDLE words.
- Its output feeds the MII transmit lanes and the link checker.

Parameters:
- DATA_WIDTH, 64, transmit data width; fixed at 8 byte lanes.
- CTRL_WIDTH, 8, one control bit per lane.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- PREAMBLE_BYTE, 8'h55, data byte carried in lanes 1-7 of the start word.
- MIN_LEN, 46, minimum accepted payload bytes.
- MAX_LEN, 150, maximum accepted payload bytes.
- IPG_BYTES, 12, minimum IDLE bytes between TERM and the next START.
- LEN_WIDTH, 8, width of the length inputs.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  2  per-requester frame request; level-sensitive.
- i_len0  in  LEN_WIDTH  requester 0 payload length in bytes; stable while i_req[0] is high.
- i_len1  in  LEN_WIDTH  requester 1 payload length in bytes.
- i_data0  in  DATA_WIDTH  requester 0 show-ahead payload word; lane 0 is the first byte.
- i_data1  in  DATA_WIDTH  requester 1 show-ahead payload word.
- o_rd  out  2  pop strobe; the word on i_dataN is consumed at the clock edge.
- o_grant  out  2  one-hot; high while requester N owns the frame.
- o_done  out  2  one-cycle pulse at the end of a served frame.
- o_reject  out  2  one-cycle pulse when a request has an illegal length.
- o_tx_data  out  DATA_WIDTH  registered transmit data.
- o_tx_ctrl  out  CTRL_WIDTH  registered transmit control.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst sampled high at a clk edge):
  - state = IDLE.
  - o_tx_data = 64'h0707070707070707, o_tx_ctrl = 8'hFF.
  - o_rd, o_grant, o_done, o_reject, o_busy all 0.
  - Round-robin pointer set so requester 0 wins the first tie.
- Reset mid-frame aborts the frame: no o_done pulse, IDLE words from the next cycle.
- o_tx_* is loaded each cycle with the word for the current state, so it appears one cycle after that state cycle.
- States:
  - IDLE: emit an IDLE word. If any i_req is high, pick one requester (round-robin; on a tie, the one not granted last).
    - Length legal (MIN_LEN..MAX_LEN inclusive): latch len, W = ceil(len/8), r = len mod 8; go to SOF.
    - Length illegal: pulse o_reject[n], stay in IDLE, advance the pointer as if served. A requester still high on the next cycle is a new request.
  - SOF (1 cycle): emit lane 0 = START_CODE with ctrl bit 1; lanes 1-7 = PREAMBLE_BYTE with ctrl 0.
  - PAYLOAD (W cycles): o_rd[n] = 1 every cycle; emit i_dataN with ctrl 0.
    - On the last word with r != 0: lanes 0 to r-1 carry data (ctrl 0), lane r = TERM_CODE (ctrl 1), lanes above r = IDLE_CODE (ctrl 1). Tail = 7 - r.
  - TERM (only when r == 0): emit lane 0 = TERM_CODE, lanes 1-7 = IDLE_CODE, ctrl 8'hFF. Tail = 7.
  - IPG (K cycles): emit IDLE words, where K = max(0, ceil((IPG_BYTES - tail)/8) - 1). Then go to IDLE.
    - The IDLE arbitration word completes the gap, so the gap = tail + 8K + 8 ≥ IPG_BYTES.
- o_grant[n] is high from SOF through the cycle that emits TERM (last PAYLOAD or TERM state). o_done[n] pulses in that same last cycle.
- o_rd is never asserted outside PAYLOAD, and never for the non-granted requester.
- Dropping i_req during a granted frame has no effect; the frame completes.
- Frame period from START to the next START = 1 + W + (r == 0 ? 1 : 0) + K + 1 cycles.
- The length counter is LEN_WIDTH bits; W ≤ 19 at the defaults, and no wrap can occur for legal lengths.

Test Plan:
- Requester 0, len = 64:
  - o_tx shows the start word (data 64'h55555555555555FB, ctrl 8'h01), then 8 data words with ctrl 8'h00.
  - Then the TERM word (data 64'h07070707070707FD, ctrl 8'hFF), then IDLE.
  - o_rd[0] high for 8 cycles; o_done[0] pulses once; K = 0.
- Requester 1, len = 46:
  - 6 payload words; the last has ctrl 8'hC0, byte 6 = FD, byte 7 = 07.
  - Then 1 IPG word and 1 IDLE word (gap 17 bytes).
  - o_grant = 2'b10 for 7 cycles.
- Both requesters held high, len = 46:
  - Grants alternate 0, 1, 0, 1.
  - START words appear exactly 9 cycles apart; o_grant is never 2'b11.
- Illegal lengths:
  - len = 45 or 151: o_reject pulses one cycle; no o_rd, no o_grant; o_tx stays IDLE.
  - len = 150: accepted; W = 19; TERM in lane 6 of word 19.
- Reset mid-frame:
  - i_rst asserted on the 3rd PAYLOAD cycle: next cycle o_tx = IDLE word, o_grant = 0, no o_done.
  - After reset, simultaneous requests are served requester 0 first.
